// File: rtl/borrow_lookahead_serial_subtractor.sv
// Nibble-serial subtractor: D = X - Y - Bin, one 4-bit borrow-lookahead
// slice per clock, LSB nibble first, behind a valid/ready handshake.
module borrow_lookahead_serial_subtractor #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] LAST_NIB = CW'(NIB - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y;
  logic             r_borrow;
  logic [CW-1:0]    r_cnt;
  logic             r_xmsb;
  logic             r_ymsb;

  logic [3:0]       w_a;
  logic [3:0]       w_b;
  logic [3:0]       w_g;
  logic [3:0]       w_p;
  logic [4:0]       w_bw;
  logic [3:0]       w_diff;
  logic [WIDTH-1:0] w_d_next;
  logic             w_ovf_next;

  assign w_a = r_x[3:0];
  assign w_b = r_y[3:0];

  // Borrow-lookahead slice: every internal borrow is a flat sum of products
  // of generate/propagate terms and the incoming borrow, no ripple.
  always_comb begin
    w_g     = ~w_a & w_b;
    w_p     = ~(w_a ^ w_b);
    w_bw    = '0;
    w_bw[0] = r_borrow;
    w_bw[1] = w_g[0] | (w_p[0] & r_borrow);
    w_bw[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & r_borrow);
    w_bw[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
            | (w_p[2] & w_p[1] & w_p[0] & r_borrow);
    w_bw[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
            | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
            | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & r_borrow);
    w_diff  = w_a ^ w_b ^ w_bw[3:0];
  end

  // New difference nibble enters at the top; a single-nibble build has no
  // older bits to shift down.
  generate
    if (WIDTH == 4) begin : g_single
      assign w_d_next = w_diff;
    end else begin : g_multi
      assign w_d_next = {w_diff, d[WIDTH-1:4]};
    end
  endgenerate

  // On the last nibble w_diff[3] is the result MSB.
  assign w_ovf_next = (r_xmsb ^ r_ymsb) & (r_xmsb ^ w_diff[3]);

  // Control FSM plus datapath registers; all outputs are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      d         <= '0;
      bout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
      r_x       <= '0;
      r_y       <= '0;
      r_borrow  <= 1'b0;
      r_cnt     <= '0;
      r_xmsb    <= 1'b0;
      r_ymsb    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_x      <= x;
            r_y      <= y;
            r_borrow <= bin;
            r_cnt    <= '0;
            r_xmsb   <= x[WIDTH-1];
            r_ymsb   <= y[WIDTH-1];
            in_ready <= 1'b0;
            r_state  <= S_RUN;
          end
        end
        S_RUN: begin
          r_x      <= r_x >> 4;
          r_y      <= r_y >> 4;
          r_borrow <= w_bw[4];
          d        <= w_d_next;
          r_cnt    <= r_cnt + CW'(1);
          if (r_cnt == LAST_NIB) begin
            bout      <= w_bw[4];
            ovf       <= w_ovf_next;
            zero      <= (w_d_next == '0);
            out_valid <= 1'b1;
            r_state   <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_borrow_lookahead_serial_subtractor.sv
// Scoreboard bench: stimulus pushes hand-computed results, a negedge
// monitor pops and compares on each output handshake.
module tb_borrow_lookahead_serial_subtractor;

  localparam int WIDTH = 16;
  localparam int LAT   = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] x = '0;
  logic [WIDTH-1:0] y = '0;
  logic             bin = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] d;
  logic             bout;
  logic             ovf;
  logic             zero;

  typedef struct {
    logic [WIDTH-1:0] d;
    logic             bout;
    logic             ovf;
    logic             zero;
    int               acc_cyc;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  bit   seen    = 1'b0;

  borrow_lookahead_serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .d(d), .bout(bout), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: latency on first sight, hold checks while stalled, pop on handshake.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (q.size() == 0) begin
        check("unexpected_out_valid", 32'(out_valid), 32'd0);
      end else begin
        if (!seen) begin
          check("latency", 32'(cyc - q[0].acc_cyc), 32'(LAT));
          seen = 1'b1;
        end
        check("in_ready_while_valid", 32'(in_ready), 32'd0);
        if (!out_ready) begin
          check("hold_d", 32'(d), 32'(q[0].d));
          check("hold_zero", 32'(zero), 32'(q[0].zero));
        end else begin
          check("d", 32'(d), 32'(q[0].d));
          check("bout", 32'(bout), 32'(q[0].bout));
          check("ovf", 32'(ovf), 32'(q[0].ovf));
          check("zero", 32'(zero), 32'(q[0].zero));
          $display("[TB] result d=%h bout=%0d ovf=%0d zero=%0d", d, bout, ovf, zero);
          void'(q.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  // Drive one operand set and push its expected result when accepted.
  task automatic issue(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] ya, input logic ba,
                       input logic [WIDTH-1:0] ed, input logic eb, input logic eo, input logic ez);
    exp_t e;
    int   n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("wait_in_ready", 32'(in_ready), 32'd1);
    x = xa; y = ya; bin = ba; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    e.d = ed; e.bout = eb; e.ovf = eo; e.zero = ez; e.acc_cyc = cyc;
    q.push_back(e);
    $display("[TB] issue x=%h y=%h bin=%0d expect d=%h bout=%0d ovf=%0d zero=%0d",
             xa, ya, ba, ed, eb, eo, ez);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((q.size() != 0 || out_valid) && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("op_completes", 32'(q.size()), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_d"}, 32'(d), 32'd0);
    check({tag, "_bout"}, 32'(bout), 32'd0);
    check({tag, "_ovf"}, 32'(ovf), 32'd0);
    check({tag, "_zero"}, 32'(zero), 32'd0);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);
    check_reset_vals("post_reset");

    issue(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0); wait_done();
    issue(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0); wait_done();
    issue(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0); wait_done();
    issue(16'hABCD, 16'hABCD, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1); wait_done();
    issue(16'hABCD, 16'hABCD, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0); wait_done();
    issue(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0); wait_done();

    // Backpressure: stall 6 cycles while offering operands that must be ignored.
    out_ready = 1'b0;
    issue(16'h5555, 16'h1111, 1'b0, 16'h4444, 1'b0, 1'b0, 1'b0);
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("bp_out_valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < 6; i++) begin
      x = 16'hFFFF; y = 16'h0000; bin = 1'b0;
      in_valid = ~in_valid;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_done();
    repeat (8) @(posedge clk);
    #1;
    check("bp_no_extra_accept", 32'(out_valid), 32'd0);

    // Reset two cycles into RUN: result dropped, no out_valid.
    issue(16'h1234, 16'h0001, 1'b0, 16'h1233, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    void'(q.pop_back());
    seen = 1'b0;
    @(negedge clk);
    check_reset_vals("mid_run_reset");
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("no_valid_after_reset", 32'(out_valid), 32'd0);

    issue(16'h0010, 16'h0001, 1'b0, 16'h000F, 1'b0, 1'b0, 1'b0); wait_done();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/borrow_lookahead_serial_subtractor.md
# borrow_lookahead_serial_subtractor

Multi-cycle unsigned/two's-complement subtractor computing D = X − Y − Bin over WIDTH bits, one 4-bit nibble per clock, LSB nibble first. Each nibble uses a borrow-lookahead stage: generate ~a&b, propagate ~(a^b), borrows resolved in parallel within the nibble. The borrow chains between nibbles through a registered borrow. It is the subtract-direction companion of the team's carry-lookahead adders and sits behind a valid/ready pair so an upstream datapath can stream operands into it.

## Interface
- WIDTH, 16, operand and result width; must be a multiple of 4 and ≥ 4; NIB = WIDTH/4.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands present.
- in_ready  out  1  block can accept operands.
- x  in  WIDTH  minuend.
- y  in  WIDTH  subtrahend.
- bin  in  1  borrow-in.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts result.
- d  out  WIDTH  difference x − y − bin, modulo 2^WIDTH.
- bout  out  1  borrow-out; 1 iff x < y + bin (unsigned).
- ovf  out  1  signed overflow: (x[MSB]^y[MSB]) & (x[MSB]^d[MSB]).
- zero  out  1  d == 0.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&in_ready, capture x, y into shift registers, load the borrow register with bin, clear the nibble counter, and go to RUN.
- RUN: each cycle, the low nibble of the x and y shift registers plus the borrow register feed the lookahead stage. The 4 difference bits shift into the top of the d register (shift right by 4). The stage's borrow-out loads the borrow register. The counter increments. After nibble NIB−1 is processed, go to DONE.
- DONE: out_valid=1. d, bout, ovf and zero are stable and held until out_ready=1. On out_valid&out_ready, go to IDLE.
- in_ready=1 only in IDLE. in_valid in RUN or DONE is ignored and does not alter captured operands.
- ovf uses the captured x[MSB] and y[MSB]. zero is computed from the final d register.
- Lookahead stage within a nibble: b[i+1] = g[i] | p[i]&b[i], expanded two-level (no ripple). Difference bit = a^b^borrow.
- rst asserted at any time, including mid-RUN or in DONE: state→IDLE. The result is lost and no out_valid pulse occurs.

## Timing
- Reset values: in_ready=1, out_valid=0, d=0, bout=0, ovf=0, zero=0 (zero flag is registered, not decoded from d during reset).
- Accept on clock edge T. Nibble k is processed on edge T+1+k.
- out_valid rises after edge T+NIB, i.e. the result is visible NIB cycles after acceptance (4 for WIDTH=16).
- The earliest next acceptance is on the edge after the output handshake. Minimum throughput is one op per NIB+2 cycles.
- Outputs are registered; no combinational path from inputs to outputs.
- out_valid is never deasserted without a handshake, except by rst.

## Test plan
- x=16'h1234, y=16'h0234, bin=0 -> d=16'h1000, bout=0, ovf=0, zero=0; out_valid exactly 4 cycles after accept.
- x=16'h0000, y=16'h0001, bin=0 -> d=16'hFFFF, bout=1, ovf=0, zero=0; the borrow propagates through all 4 nibbles.
- x=16'h8000, y=16'h0001, bin=0 -> d=16'h7FFF, bout=0, ovf=1.
- x=16'hABCD, y=16'hABCD, bin=0 -> d=0, zero=1, bout=0. Then rerun with bin=1 -> d=16'hFFFF, bout=1, zero=0.
- Backpressure: hold out_ready=0 for 6 cycles after out_valid while pulsing in_valid with new operands -> d, bout, ovf, zero are held, in_ready stays 0, and the new operands are not accepted.
- Assert rst 2 cycles into RUN -> next cycle in_ready=1, out_valid=0, all outputs 0. A following op 16'h0010−16'h0001 gives d=16'h000F.
